lsu_store_buffer: RTL

//  Load/store unit between the pipeline MEM stage and the ram block; sole driver of ram's load/store/access/addr/data_in.

---
 rtl/lsu_store_buffer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: load/store unit sitting between the MEM stage and the ram
// block. Stores are posted into an in-order FIFO and written back whenever the
// ram port is idle. Loads use the port directly, one-cycle latency. Illegal or
// misaligned requests are answered with resp_err and never reach ram. The
// flush handshake (RUN -> FLUSH -> DONE) empties the FIFO for fences and halts.
//
// Optional feature macro: STORE_FWD_EN
//   defined   : a load hitting a pending word store (youngest match) is
//               answered from the FIFO without stalling and without ram_load.
//   undefined : every load that overlaps a pending store stalls until drained.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal operation, requests accepted, FIFO drains when idle
// FLUSH | requests blocked, FIFO drains every cycle until empty
// DONE  | FIFO empty, flush_done high until flush_req drops

module lsu_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_access,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        ram_load,
  output logic        ram_store,
  output logic [2:0]  ram_access,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] ACC_B  = 3'b000;
  localparam logic [2:0] ACC_H  = 3'b001;
  localparam logic [2:0] ACC_W  = 3'b010;
  localparam logic [2:0] ACC_BU = 3'b100;
  localparam logic [2:0] ACC_HU = 3'b101;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    ent_access_q [DEPTH];
  logic [2:0]    ent_access_d [DEPTH];
  logic [31:0]   ent_addr_q   [DEPTH];
  logic [31:0]   ent_addr_d   [DEPTH];
  logic [31:0]   ent_wdata_q  [DEPTH];
  logic [31:0]   ent_wdata_d  [DEPTH];
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  logic req_legal;
  logic req_is_load;
  logic hazard_any;
  logic stall;
  logic accept;
  logic load_fire;
  logic push;
  logic pop;

`ifdef STORE_FWD_EN
  logic [PW-1:0] young_idx;
  logic          fwd_hit;
  logic          fwd_take;
  logic [31:0]   fwd_word;
  logic [31:0]   fwd_lane;
  logic [31:0]   fwd_data;
`endif

  // Access legality: code supported for the direction and natural alignment.
  always_comb begin
    req_legal = 1'b0;
    case (req_access)
      ACC_B:   req_legal = 1'b1;
      ACC_H:   req_legal = ~req_addr[0];
      ACC_W:   req_legal = (req_addr[1:0] == 2'b00);
      ACC_BU:  req_legal = ~req_store;
      ACC_HU:  req_legal = ~req_store & ~req_addr[0];
      default: req_legal = 1'b0;
    endcase
    req_is_load = ~req_store & req_legal;
  end

  // Word-address match against every live FIFO entry, oldest to youngest.
  always_comb begin
    hazard_any = 1'b0;
`ifdef STORE_FWD_EN
    young_idx = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) &&
          (ent_addr_q[head_q + PW'(i)][31:2] == req_addr[31:2])) begin
        hazard_any = 1'b1;
`ifdef STORE_FWD_EN
        young_idx = head_q + PW'(i);
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  // Forward from the youngest matching entry only when it holds a full word.
  always_comb begin
    fwd_hit  = hazard_any && (ent_access_q[young_idx] == ACC_W);
    fwd_word = ent_wdata_q[young_idx];
    fwd_lane = fwd_word >> {req_addr[1:0], 3'b000};
    fwd_data = 32'h0;
    case (req_access)
      ACC_B:   fwd_data = {{24{fwd_lane[7]}}, fwd_lane[7:0]};
      ACC_BU:  fwd_data = {24'h0, fwd_lane[7:0]};
      ACC_H:   fwd_data = {{16{fwd_lane[15]}}, fwd_lane[15:0]};
      ACC_HU:  fwd_data = {16'h0, fwd_lane[15:0]};
      ACC_W:   fwd_data = fwd_word;
      default: fwd_data = 32'h0;
    endcase
    stall = hazard_any && !fwd_hit;
  end
`else
  // Without forwarding any overlap with a pending store must wait for drain.
  always_comb begin
    stall = hazard_any;
  end
`endif

  // Handshake, port arbitration and ram port drive.
  always_comb begin
    req_ready = (state_q == ST_RUN) && (count_q < CW'(DEPTH)) &&
                !(req_is_load && stall);
    accept    = req_valid && req_ready;
`ifdef STORE_FWD_EN
    fwd_take  = accept && req_is_load && fwd_hit;
    load_fire = accept && req_is_load && !fwd_hit;
`else
    load_fire = accept && req_is_load;
`endif
    push      = accept && req_store && req_legal;
    pop       = (count_q != '0) && !load_fire;

    ram_load    = load_fire;
    ram_store   = pop;
    ram_access  = 3'b000;
    ram_addr    = 32'h0;
    ram_data_in = 32'h0;
    if (load_fire) begin
      ram_access = req_access;
      ram_addr   = req_addr;
    end else if (pop) begin
      ram_access  = ent_access_q[head_q];
      ram_addr    = ent_addr_q[head_q];
      ram_data_in = ent_wdata_q[head_q];
    end
  end

  // FIFO pointers, occupancy and entry storage.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    ent_access_d = ent_access_q;
    ent_addr_d   = ent_addr_q;
    ent_wdata_d  = ent_wdata_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d               = tail_q + PW'(1);
      ent_access_d[tail_q] = req_access;
      ent_addr_d[tail_q]   = req_addr;
      ent_wdata_d[tail_q]  = req_wdata;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Response registered one cycle after acceptance; stores answer as posted.
  always_comb begin
    resp_valid_d = accept;
    resp_err_d   = accept && !req_legal;
`ifdef STORE_FWD_EN
    resp_rdata_d = load_fire ? ram_data_out : (fwd_take ? fwd_data : 32'h0);
`else
    resp_rdata_d = load_fire ? ram_data_out : 32'h0;
`endif
  end

  // Flush sequencing; FLUSH exits on the occupancy seen at the start of a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: if (count_q == '0) state_d = ST_DONE;
      ST_DONE:  if (!flush_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // State registers; reset discards any pending stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_access_q[i] <= 3'b000;
        ent_addr_q[i]   <= 32'h0;
        ent_wdata_q[i]  <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      ent_access_q <= ent_access_d;
      ent_addr_q   <= ent_addr_d;
      ent_wdata_q  <= ent_wdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign flush_done = (state_q == ST_DONE);

endmodule
